// File: rtl/spi_controller_pkg.sv
// spi_controller_pkg: FSM states, config field positions and reset defaults for spi_controller.
package spi_controller_pkg;
  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_e;
  localparam int CFG_WR = 0;
  localparam int CFG_MODE = 1;
  localparam int CFG_RATIO = 3;
  localparam int MIN_RATIO = 2;
  localparam logic [1:0] RST_MODE = 2'd0;
  localparam int RST_RATIO = 2;
  function automatic int half_of(input int ratio);
    return (ratio < MIN_RATIO ? MIN_RATIO : ratio) >> 1;
  endfunction
endpackage

// File: rtl/spi_sclk_gen.sv
// spi_sclk_gen: half-period counter producing the SCLK level, mid/end-of-bit strobes and bit count.
module spi_sclk_gen #(
  parameter int DATA_W = 8,
  parameter int RATIO_W = 8,
  parameter int BIT_W = $clog2(DATA_W)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               run_i,
  input  logic               high_i,
  input  logic               start_i,
  input  logic               idle_lvl_i,
  input  logic [RATIO_W-1:0] half_i,
  output logic               sclk_o,
  output logic               mid_o,
  output logic               end_o,
  output logic               last_o,
  output logic [BIT_W-1:0]   bit_o
);
  logic [RATIO_W-1:0] cnt_q, cnt_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic sclk_q, sclk_d, tick;
  assign tick = run_i && cnt_q == half_i - 1'b1;
  assign mid_o = tick && !high_i;
  assign end_o = tick && high_i;
  assign last_o = bit_q == BIT_W'(DATA_W - 1);
  assign sclk_o = sclk_q;
  assign bit_o = bit_q;
  // Every bit is LOW then HIGH; only the idle level depends on CPOL.
  always_comb begin
    cnt_d = (!run_i || tick) ? '0 : cnt_q + 1'b1;
    bit_d = !run_i ? '0 : bit_q + BIT_W'(end_o);
    sclk_d = !run_i ? !start_i && idle_lvl_i : mid_o ? 1'b1 : end_o ? last_o && idle_lvl_i : sclk_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      bit_q <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      sclk_q <= sclk_d;
    end
  end
endmodule

// File: rtl/spi_controller.sv
// spi_controller: single-byte SPI master with runtime mode/ratio config.
// Define SPI_LOOPBACK_EN to add i_loopback, which samples o_copi instead of i_cipo.
module spi_controller
  import spi_controller_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int RATIO_W = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [RATIO_W+2:0] i_config,
  input  logic [DATA_W-1:0]  i_tx,
  input  logic               i_tx_valid,
  input  logic               i_cipo,
`ifdef SPI_LOOPBACK_EN
  input  logic               i_loopback,
`endif
  output logic               o_ready,
  output logic [DATA_W-1:0]  o_rx,
  output logic               o_rx_valid,
  output logic               o_copi,
  output logic               o_sclk
);
  localparam int BIT_W = $clog2(DATA_W);
  state_e state_q;
  logic [1:0] mode_q;
  logic [RATIO_W-1:0] half_q;
  logic [DATA_W-1:0] tx_q, rx_sh_q, rx_q;
  logic ready_q, valid_q, copi_q;
  logic cfg_wr, idle, start, cpha, sample, mid, endb, last;
  logic [1:0] cfg_mode;
  logic [RATIO_W-1:0] cfg_ratio;
  logic [BIT_W-1:0] bit_idx;
  assign cfg_wr = i_config[CFG_WR];
  assign cfg_mode = i_config[CFG_MODE +: 2];
  assign cfg_ratio = i_config[CFG_RATIO +: RATIO_W];
  assign idle = state_q == IDLE;
  assign start = idle && !cfg_wr && i_tx_valid;
  assign cpha = mode_q[0];
`ifdef SPI_LOOPBACK_EN
  assign sample = i_loopback ? copi_q : i_cipo;
`else
  assign sample = i_cipo;
`endif
  spi_sclk_gen #(.DATA_W(DATA_W), .RATIO_W(RATIO_W)) u_sclk (
    .clk_i(i_clk),
    .rst_i(i_rst),
    .run_i(!idle),
    .high_i(state_q == HIGH),
    .start_i(start),
    .idle_lvl_i(idle && cfg_wr ? cfg_mode[1] : mode_q[1]),
    .half_i(half_q),
    .sclk_o(o_sclk),
    .mid_o(mid),
    .end_o(endb),
    .last_o(last),
    .bit_o(bit_idx)
  );
  // A config write in IDLE takes priority over a start request.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      mode_q <= RST_MODE;
      half_q <= RATIO_W'(half_of(RST_RATIO));
      tx_q <= '0;
      rx_sh_q <= '0;
      rx_q <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      copi_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE:
          if (cfg_wr) begin
            mode_q <= cfg_mode;
            half_q <= RATIO_W'(half_of(int'(cfg_ratio)));
          end else if (i_tx_valid) begin
            tx_q <= i_tx;
            state_q <= LOW;
            ready_q <= 1'b0;
            copi_q <= !cpha && i_tx[DATA_W-1];
          end
        LOW:
          if (mid) begin
            state_q <= HIGH;
            if (cpha) copi_q <= tx_q[BIT_W'(DATA_W - 1) - bit_idx];
          end
        HIGH:
          if (endb) begin
            rx_sh_q <= {rx_sh_q[DATA_W-2:0], sample};
            if (last) begin
              state_q <= IDLE;
              rx_q <= {rx_sh_q[DATA_W-2:0], sample};
              valid_q <= 1'b1;
              ready_q <= 1'b1;
              copi_q <= 1'b0;
            end else begin
              state_q <= LOW;
              if (!cpha) copi_q <= tx_q[BIT_W'(DATA_W - 2) - bit_idx];
            end
          end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign o_ready = ready_q;
  assign o_rx = rx_q;
  assign o_rx_valid = valid_q;
  assign o_copi = copi_q;
endmodule

// File: tb/tb_spi_controller.sv
// tb_spi_controller: scoreboard bench for spi_controller with a cycle-level peripheral model.
module tb_spi_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [10:0] cfg = '0;
  logic [7:0] tx = '0;
  logic tx_valid = 1'b0;
  logic cipo = 1'b0;
  logic ready, rx_valid, copi, sclk;
  logic [7:0] rx;
  logic [1:0] cur_mode = 2'd0;
  logic [7:0] exp_q[$];
  int checks = 0;
  int errors = 0;
`ifdef SPI_LOOPBACK_EN
  logic loopback = 1'b0;
`endif

  spi_controller dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_config(cfg),
    .i_tx(tx),
    .i_tx_valid(tx_valid),
    .i_cipo(cipo),
`ifdef SPI_LOOPBACK_EN
    .i_loopback(loopback),
`endif
    .o_ready(ready),
    .o_rx(rx),
    .o_rx_valid(rx_valid),
    .o_copi(copi),
    .o_sclk(sclk)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic set_cfg(input logic [7:0] ratio, input logic [1:0] mode);
    @(negedge clk);
    cfg = {ratio, mode, 1'b1};
    @(negedge clk);
    cfg = '0;
    cur_mode = mode;
    checks++;
    if (sclk !== mode[1]) begin
      errors++;
      $display("FAIL cfg_idle_sclk: got %b, required %b", sclk, mode[1]);
    end
  endtask

  // Peripheral drives bit k of r at the k-th SCLK rise; COPI is captured at the same point.
  task automatic xfer(input logic [7:0] t, input logic [7:0] r, input int ratio,
                      input bit cfg_mid, input bit chained, input bit hold);
    int cyc, rises;
    logic prev;
    logic [7:0] bits, exp;
    if (!chained) @(negedge clk);
    tx = t;
    tx_valid = 1'b1;
    exp_q.push_back(r);
    @(negedge clk);
    if (!hold) tx_valid = 1'b0;
    cyc = 0;
    rises = 0;
    prev = 1'b0;
    bits = '0;
    while (!ready && cyc <= 8 * ratio + 16) begin
      if (sclk && !prev) begin
        bits = {bits[6:0], copi};
        if (rises < 8) cipo = r[3'(7 - rises)];
        rises++;
      end
      prev = sclk;
      cyc++;
      cfg = (cfg_mid && cyc == 3) ? {8'd2, 2'b11, 1'b1} : '0;
      @(negedge clk);
    end
    exp = exp_q.pop_front();
    checks++;
    if (cyc !== 8 * ratio) begin
      errors++;
      $display("FAIL busy_cycles: got %0d, required %0d", cyc, 8 * ratio);
    end
    checks++;
    if (rises !== 8) begin
      errors++;
      $display("FAIL sclk_rises: got %0d, required 8", rises);
    end
    checks++;
    if (bits !== t) begin
      errors++;
      $display("FAIL copi_bits: got %h, required %h", bits, t);
    end
    checks++;
    if (rx_valid !== 1'b1) begin
      errors++;
      $display("FAIL rx_valid_pulse: got %b, required 1", rx_valid);
    end
    checks++;
    if (rx !== exp) begin
      errors++;
      $display("FAIL rx_data: got %h, required %h", rx, exp);
    end
    if (!hold) begin
      @(negedge clk);
      checks++;
      if (rx_valid !== 1'b0) begin
        errors++;
        $display("FAIL rx_valid_one_cycle: got %b, required 0", rx_valid);
      end
      checks++;
      if (sclk !== cur_mode[1]) begin
        errors++;
        $display("FAIL sclk_idle: got %b, required %b", sclk, cur_mode[1]);
      end
      checks++;
      if (copi !== 1'b0) begin
        errors++;
        $display("FAIL copi_idle: got %b, required 0", copi);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b, required 1", ready); end
    checks++;
    if (sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b, required 0", sclk); end
    checks++;
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b, required 0", rx_valid); end
    checks++;
    if (rx !== 8'h00) begin errors++; $display("FAIL reset_rx: got %h, required 00", rx); end
    checks++;
    if (copi !== 1'b0) begin errors++; $display("FAIL reset_copi: got %b, required 0", copi); end
  endtask

  task automatic test_mode0();
    xfer(8'hA5, 8'h3C, 2, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_cfg_priority();
    @(negedge clk);
    cfg = {8'd2, 2'b00, 1'b1};
    tx = 8'hFF;
    tx_valid = 1'b1;
    @(negedge clk);
    cfg = '0;
    tx_valid = 1'b0;
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL cfg_wins_over_start: ready got %b, required 1", ready); end
    @(negedge clk);
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL cfg_no_late_start: ready got %b, required 1", ready); end
  endtask

  task automatic test_ratio_bounds();
    set_cfg(8'd0, 2'b00);
    xfer(8'h81, 8'h7E, 2, 1'b0, 1'b0, 1'b0);
    set_cfg(8'd1, 2'b00);
    xfer(8'h5A, 8'hC3, 2, 1'b0, 1'b0, 1'b0);
    set_cfg(8'd5, 2'b00);
    xfer(8'h0F, 8'hF0, 4, 1'b0, 1'b0, 1'b0);
    set_cfg(8'd3, 2'b00);
    xfer(8'hFF, 8'h00, 2, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random(input logic [7:0] ratio, input logic [1:0] mode);
    logic [7:0] a, b;
    set_cfg(ratio, mode);
    for (int i = 0; i < 255; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      xfer(a, b, int'(ratio), 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_cfg_during_busy();
    set_cfg(8'd4, 2'b01);
    xfer(8'h96, 8'h69, 4, 1'b1, 1'b0, 1'b0);
    xfer(8'h3C, 8'hA5, 4, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    set_cfg(8'd2, 2'b00);
    xfer(8'h12, 8'h34, 2, 1'b0, 1'b0, 1'b1);
    xfer(8'hC7, 8'h2E, 2, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid();
    logic seen;
    set_cfg(8'd8, 2'b11);
    @(negedge clk);
    tx = 8'hFF;
    tx_valid = 1'b1;
    cipo = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    seen = 1'b0;
    repeat (20) begin @(negedge clk); seen |= rx_valid; end
    rst = 1'b1;
    repeat (2) begin @(negedge clk); seen |= rx_valid; end
    rst = 1'b0;
    cur_mode = 2'b00;
    @(negedge clk);
    seen |= rx_valid;
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b, required 1", ready); end
    checks++;
    if (sclk !== 1'b0) begin errors++; $display("FAIL abort_sclk: got %b, required 0", sclk); end
    checks++;
    if (copi !== 1'b0) begin errors++; $display("FAIL abort_copi: got %b, required 0", copi); end
    checks++;
    if (rx !== 8'h00) begin errors++; $display("FAIL abort_rx: got %h, required 00", rx); end
    repeat (80) begin @(negedge clk); seen |= rx_valid; end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_rx_valid: got %b, required 0", seen); end
    xfer(8'hE1, 8'h1E, 2, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_cfg_priority();
    test_ratio_bounds();
    test_random(8'd4, 2'b01);
    test_random(8'd6, 2'b10);
    test_random(8'd8, 2'b11);
    test_cfg_during_busy();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_controller.md
Name: spi_controller

Overview:
- Single-byte SPI controller (bus master) with runtime-selectable SPI mode (0-3) and SCLK divider.
- Accepts a byte on a valid/ready handshake, shifts it out on COPI MSB-first, and captures 8 bits from CIPO.
- Returns the received byte with a one-cycle valid strobe.
- Sits between a host-side register/FSM and an external peripheral; chip select is handled outside this block.

Parameters:
- DATA_W, 8, bits per transfer.
- RATIO_W, 8, width of clock-ratio config field; i_config width = RATIO_W+3.

Ports:
- i_clk  in  1  system clock, all logic on rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_config  in  RATIO_W+3  {ratio[RATIO_W-1:0], mode[1:0], wr}. Config is latched when wr=1.
- i_tx  in  DATA_W  byte to transmit.
- i_tx_valid  in  1  start request.
- i_cipo  in  1  serial data from peripheral.
- o_ready  out  1  idle; a start request is accepted.
- o_rx  out  DATA_W  last received byte.
- o_rx_valid  out  1  one-cycle pulse when o_rx updates.
- o_copi  out  1  serial data to peripheral.
- o_sclk  out  1  serial clock.

Behaviour:
- Reset values: o_ready=1, o_rx=0, o_rx_valid=0, o_copi=0, o_sclk=0.
  - Reset config is mode 0, ratio 2.
  - Reset mid-transfer aborts it; no o_rx_valid is produced.
- Config write:
  - In IDLE with wr=1, latch mode and ratio.
  - Ignored while busy.
  - If wr=1 and i_tx_valid=1 in the same IDLE cycle, the config write wins and no transfer starts.
- Clock ratio = system clocks per SCLK period; half = ratio>>1.
  - Ratio <2 is treated as 2.
  - Odd ratios are rounded down.
- CPOL=mode[1], CPHA=mode[0]. In IDLE, o_sclk=CPOL.
- States:
  - IDLE: on i_tx_valid&o_ready at edge t, latch i_tx into the shift register. o_ready=0 from t; the transfer begins at t.
  - LOW: first half of a bit period, o_sclk=0, lasting half clocks.
  - HIGH: second half, o_sclk=1, lasting half clocks.
  - Each bit period is LOW then HIGH. The rising SCLK edge is mid-bit for every mode.
  - For CPOL=0, SCLK falls back to idle at the end of each bit.
  - For CPOL=1, SCLK falls at the start of each bit and stays high after the final bit.
- Sampling:
  - i_cipo is sampled at the end of each bit period, half an SCLK period after each rising edge, in all modes.
  - Bits are captured MSB-first, 8 samples in total.
- COPI timing, MSB-first:
  - CPHA=0: bit 7 is driven from the start cycle; each following bit is driven at the start of its bit period.
  - CPHA=1: each bit is driven at its mid-bit rising edge; the previous value is held before that.
  - o_copi returns to 0 in IDLE.
- Completion:
  - Transfer length is exactly 8*ratio clocks.
  - On the cycle after the 8th sample, o_rx takes the assembled byte, o_rx_valid=1 for one cycle, and o_ready=1 in that same cycle (state IDLE).
  - o_rx holds until the next completion.
  - A new request is accepted in that same cycle.
  - i_tx_valid held high is not a continuous request. The controller restarts only if i_tx_valid is high while o_ready=1.

Optional Feature:
- SPI_LOOPBACK_EN defined:
  - Adds port i_loopback (in, 1).
  - When i_loopback=1, sampling uses internal o_copi instead of i_cipo, so o_rx equals the transmitted byte.
- Undefined: the port is absent and sampling always uses i_cipo.

Decomposition:
- Package spi_controller_pkg: state enum (IDLE, LOW, HIGH), config field bit positions, MIN_RATIO=2, reset defaults.
- Sub-module spi_sclk_gen:
  - Half-period counter from the latched ratio.
  - Produces o_sclk level, mid-bit strobe, end-of-bit strobe and bit counter.
  - The top level holds the FSM, shift registers and handshake.

Test Plan:
- Reset -> o_ready=1 on the first cycle after i_rst drops; o_sclk=0; o_rx_valid=0.
- Mode 0, ratio 2: send 0xA5 while peripheral drives 0x3C -> 8 SCLK rises, o_copi 1,0,1,0,0,1,0,1, o_rx=0x3C with a one-cycle o_rx_valid, busy for exactly 16 clocks.
- Mode 1, ratio 4: random tx/rx byte pairs, 255 iterations -> o_rx matches the peripheral byte each time.
- Mode 2, ratio 6 -> o_sclk idles high.
- Mode 3, ratio 8 -> o_sclk idles high.
- Modes 2 and 3: 255 random iterations each -> o_rx correct each time, SCLK period 6/8 clocks.
- Config write with wr=1 during a transfer -> ignored; mode/ratio unchanged for the next transfer.
- i_rst asserted mid-transfer -> no o_rx_valid, o_ready=1 after release, outputs at reset values.
